// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation search controller.
package sar_pkg;

    localparam int STATE_W = 4;
    localparam int W_DEF   = 4;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 4'b1000,
        S_DRIVE  = 4'b0100,
        S_SAMPLE = 4'b0010,
        S_DONE   = 4'b0001
    } state_t;

endpackage

// File: rtl/sar_search_ctrl_if.sv
// Search/compare interface between the SAR controller and its environment.
// Optional err flag present when SAR_CMP_CHECK_EN is defined.
interface sar_search_ctrl_if #(
    parameter int W  = 4,
    parameter int IW = 3
);
    logic          start;
    logic          cmp_eq;
    logic          cmp_lt;
    logic          cmp_gt;
    logic [W-1:0]  guess;
    logic          busy;
    logic          done;
    logic          found;
    logic [W-1:0]  result;
    logic [IW-1:0] iter;
`ifdef SAR_CMP_CHECK_EN
    logic          err;

    modport master (
        input  start, cmp_eq, cmp_lt, cmp_gt,
        output guess, busy, done, found, result, iter, err
    );
    modport slave (
        output start, cmp_eq, cmp_lt, cmp_gt,
        input  guess, busy, done, found, result, iter, err
    );
`else
    modport master (
        input  start, cmp_eq, cmp_lt, cmp_gt,
        output guess, busy, done, found, result, iter
    );
    modport slave (
        output start, cmp_eq, cmp_lt, cmp_gt,
        input  guess, busy, done, found, result, iter
    );
`endif
endinterface

// File: rtl/sar_bitsel.sv
// Bit-index decoder: one-hot W-bit mask with bit k set.
module sar_bitsel #(
    parameter int W  = 4,
    parameter int IW = 3
) (
    input  logic [IW-1:0] k,
    output logic [W-1:0]  mask
);

    always_comb begin
        mask = '0;
        for (int i = 0; i < W; i++) begin
            mask[i] = (k == IW'(i));
        end
    end

endmodule

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller, MSB-first, driving an external comparator.
// Define SAR_CMP_CHECK_EN to flag non-one-hot comparator responses on err.
//
// state    | meaning
// S_IDLE   | waiting for start; guess holds last result
// S_DRIVE  | present result | (1<<k) on guess
// S_SAMPLE | comparator settled; decide bit k
// S_DONE   | one-cycle done pulse, guess returns to result
module sar_search_ctrl
    import sar_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int IW = 3
) (
    input  logic              clk,
    input  logic              rst_b,
    sar_search_ctrl_if.master bus
);

    state_t        state;
    logic [IW-1:0] k;
    logic [W-1:0]  mask;
    logic [W-1:0]  guess_q;
    logic [W-1:0]  result_q;
    logic [IW-1:0] iter_q;
    logic          busy_q;
    logic          done_q;
    logic          found_q;
    logic          keep_bit;
    logic          last_bit;

    sar_bitsel #(.W(W), .IW(IW)) u_bitsel (
        .k    (k),
        .mask (mask)
    );

    // gt wins over lt, and silence is read as gt, so only a clean lt keeps the bit
    assign keep_bit = bus.cmp_lt & ~bus.cmp_gt;
    assign last_bit = (k == '0);

`ifdef SAR_CMP_CHECK_EN
    logic err_q;
    logic flags_ok;

    assign flags_ok = $onehot({bus.cmp_eq, bus.cmp_lt, bus.cmp_gt});
    assign bus.err  = err_q;
`endif

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state    <= S_IDLE;
            k        <= '0;
            guess_q  <= '0;
            result_q <= '0;
            iter_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
`ifdef SAR_CMP_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state    <= S_DRIVE;
                        k        <= IW'(W-1);
                        result_q <= '0;
                        iter_q   <= '0;
                        found_q  <= 1'b0;
                        busy_q   <= 1'b1;
`ifdef SAR_CMP_CHECK_EN
                        err_q    <= 1'b0;
`endif
                    end
                end
                S_DRIVE: begin
                    guess_q <= result_q | mask;
                    state   <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    iter_q <= iter_q + IW'(1);
`ifdef SAR_CMP_CHECK_EN
                    if (!flags_ok) begin
                        err_q  <= 1'b1;
                        state  <= S_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else
`endif
                    if (bus.cmp_eq) begin
                        result_q <= guess_q;
                        found_q  <= 1'b1;
                        state    <= S_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        if (keep_bit) begin
                            result_q <= guess_q;
                        end
                        if (last_bit) begin
                            state  <= S_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            k     <= k - IW'(1);
                            state <= S_DRIVE;
                        end
                    end
                end
                S_DONE: begin
                    guess_q <= result_q;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.guess  = guess_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.found  = found_q;
    assign bus.result = result_q;
    assign bus.iter   = iter_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Self-checking bench for sar_search_ctrl: behavioural comparator plus a binary-search reference model.
module tb_sar_search_ctrl;

    localparam int W  = 4;
    localparam int IW = 3;

    logic clk   = 1'b0;
    logic rst_b = 1'b0;

    always #5 clk = ~clk;

    sar_search_ctrl_if #(.W(W), .IW(IW)) bus ();

    sar_search_ctrl #(.W(W), .IW(IW)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int tgt = 0;
    int flags_mode = 0;   // 0 normal, 1 lt and gt both high, 2 all flags low

    int exp_r;
    int exp_f;
    int exp_n;
    int exp_g [W];
`ifdef SAR_CMP_CHECK_EN
    int exp_err;
`endif

    always_comb begin
        bus.cmp_eq = 1'b0;
        bus.cmp_lt = 1'b0;
        bus.cmp_gt = 1'b0;
        case (flags_mode)
            1: begin
                bus.cmp_lt = 1'b1;
                bus.cmp_gt = 1'b1;
            end
            2: ;
            default: begin
                bus.cmp_eq = (int'(bus.guess) == tgt);
                bus.cmp_lt = (int'(bus.guess) <  tgt);
                bus.cmp_gt = (int'(bus.guess) >  tgt);
            end
        endcase
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (target %0d)", tag, got, exp, tgt);
        end
    endtask

    // Binary search on integers: try each bit from the top, keep it while still below target.
    task automatic build_model(input int t, input int mode);
        int g;
        exp_r = 0;
        exp_f = 0;
        exp_n = 0;
`ifdef SAR_CMP_CHECK_EN
        exp_err = 0;
`endif
        for (int b = W-1; b >= 0; b--) begin
            g = exp_r + (1 << b);
            exp_g[exp_n] = g;
            exp_n++;
            if (mode != 0) begin
`ifdef SAR_CMP_CHECK_EN
                exp_err = 1;
                break;
`endif
            end else if (g == t) begin
                exp_r = g;
                exp_f = 1;
                break;
            end else if (g < t) begin
                exp_r = g;
            end
        end
    endtask

    task automatic run_search(input int t, input int mode, input bit pulse_start);
        int cycles;
        int gi;
        tgt        = t;
        flags_mode = mode;
        build_model(t, mode);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("busy_after_start", int'(bus.busy), 1);
`ifdef SAR_CMP_CHECK_EN
        check("err_clear", int'(bus.err), 0);
`endif
        cycles = 0;
        gi     = 0;
        while (!bus.done && cycles < 64) begin
            @(posedge clk);
            #1;
            cycles++;
            if (!bus.done && (cycles % 2 == 1) && gi < exp_n) begin
                check($sformatf("guess%0d", gi), int'(bus.guess), exp_g[gi]);
                gi++;
            end
            bus.start = (pulse_start && cycles == 3);
        end
        bus.start = 1'b0;
        check("latency", cycles, 2*exp_n);
        check("result", int'(bus.result), exp_r);
        check("found", int'(bus.found), exp_f);
        check("iter", int'(bus.iter), exp_n);
        check("busy_at_done", int'(bus.busy), 0);
`ifdef SAR_CMP_CHECK_EN
        check("err", int'(bus.err), exp_err);
`endif
        @(posedge clk);
        #1;
        check("done_width", int'(bus.done), 0);
        check("guess_hold", int'(bus.guess), exp_r);
        if (pulse_start) begin
            repeat (3) begin
                @(posedge clk);
                #1;
                check("ignored_start_done", int'(bus.done), 0);
                check("ignored_start_busy", int'(bus.busy), 0);
            end
        end
        flags_mode = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_guess"}, int'(bus.guess), 0);
        check({tag, "_result"}, int'(bus.result), 0);
        check({tag, "_iter"}, int'(bus.iter), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_found"}, int'(bus.found), 0);
`ifdef SAR_CMP_CHECK_EN
        check({tag, "_err"}, int'(bus.err), 0);
`endif
    endtask

    initial begin
        int t;
        int m;
        bus.start = 1'b0;
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_b = 1'b1;

        run_search(5, 0, 1'b0);
        run_search(0, 0, 1'b0);
        run_search(8, 0, 1'b0);
        run_search(15, 0, 1'b1);

        // abort during the second SAMPLE of a target-10 search
        tgt = 10;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("pre_reset_guess", int'(bus.guess), 12);
        rst_b = 1'b0;
        #1;
        check_zero("async_reset");
        @(negedge clk);
        rst_b = 1'b1;
        run_search(10, 0, 1'b0);

        run_search(3, 1, 1'b0);
        run_search(7, 0, 1'b0);
        run_search(9, 2, 1'b0);

        for (int i = 0; i < 20; i++) begin
            t = int'($urandom_range(0, (1 << W) - 1));
            m = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
            run_search(t, m, ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sar_search_ctrl.md
Name: sar_search_ctrl

Overview:
- Successive-approximation controller; the initiating end of the magnitude-compare interface served by the existing 4-bit comparator.
- Drives a trial value, samples the comparator's eq/lt/gt response and resolves an unknown target MSB-first.
- Used in lab datapaths as the search engine wrapped around a combinational comparator.

Parameters:
W, 4, width of guess/target/result in bits (W >= 2)
IW, 3, width of iteration counter; must hold W (default W=4 -> 3 bits)

Ports:
clk  input  1  clock, rising edge
rst_b  input  1  reset, asynchronous, active-low
start  input  1  request new search; sampled only in IDLE
cmp_eq  input  1  comparator: guess == target
cmp_lt  input  1  comparator: guess < target
cmp_gt  input  1  comparator: guess > target
guess  output  W  trial value presented to comparator x input (target on y)
busy  output  1  high in DRIVE/SAMPLE
done  output  1  one-cycle pulse when result valid
found  output  1  high with done if an eq response terminated the search
result  output  W  resolved target; held until next start
iter  output  IW  number of SAMPLE decisions taken in last/current search

Behaviour:
- Clock clk; reset rst_b, asynchronous, active-low.
- Reset: state=IDLE; guess=0, result=0, iter=0, busy=0, done=0, found=0; all from registers.
- One-hot FSM, 4 states: IDLE=4'b1000, DRIVE=4'b0100, SAMPLE=4'b0010, DONE=4'b0001.
- IDLE:
  - start=1 -> DRIVE; bit index k=W-1; result=0; iter=0; found=0.
  - start=0 -> stay in IDLE; guess holds last result.
- DRIVE: guess <= result | (1<<k); -> SAMPLE. Comparator settles during SAMPLE cycle.
- SAMPLE (decision at the edge leaving SAMPLE); iter <= iter+1.
  - cmp_eq: result <= guess, found <= 1 -> DONE (early termination).
  - cmp_lt: result <= guess (keep bit k).
  - cmp_gt: result unchanged (bit k cleared).
  - Not terminated and k==0 -> DONE; else k <= k-1 -> DRIVE.
- DONE: done=1 for exactly one cycle; guess <= result -> IDLE.
- Latency: start sampled at edge E0; each bit costs 2 cycles; done high after edge E(2n), where n = iter. Worst case n=W.
- busy = DRIVE|SAMPLE. start while busy or in DONE is ignored, not queued.
- Flag priority without check feature: eq > gt > lt; all-zero flags are treated as gt.
- Asynchronous reset mid-search aborts immediately to reset values; no partial done.
- W-bit arithmetic only; the OR-in of bit k never overflows.

Optional Feature:
- Macro SAR_CMP_CHECK_EN.
- Defined:
  - Adds output err (1 bit, reset 0).
  - In SAMPLE, if {cmp_eq,cmp_lt,cmp_gt} is not one-hot: err <= 1, go to DONE with found=0, result unchanged.
  - err clears on next accepted start.
- Undefined: no err port; priority rule above applies.

Decomposition:
- Shared package sar_pkg: one-hot state localparams (S_IDLE, S_DRIVE, S_SAMPLE, S_DONE), state width 4, default W.
- One natural sub-module, sar_bitsel: W-bit decoder producing the 1<<k mask from the k counter.
- The comparator itself stays external; the bench instantiates it as the responder.

Test Plan:
- Target 5, W=4, start at E0 -> guesses 8(gt), 4(lt), 6(gt), 5(eq); done after E8; result=5, found=1, iter=4.
- Target 0 -> guesses 8,4,2,1 all gt; done after E8; result=0, found=0, iter=4.
- Target 8 -> guess 8 eq on first SAMPLE; done after E2; result=8, found=1, iter=1; busy low next cycle.
- Target 15 -> guesses 8,12,14 lt, then 15 eq; result=15, iter=4. Start pulsed during busy is ignored; no second done.
- rst_b driven low during the second SAMPLE of a target-10 search -> outputs return to 0 immediately; a fresh start then resolves 10 correctly.
- With SAR_CMP_CHECK_EN, force cmp_lt=cmp_gt=1 on the first SAMPLE -> err=1, done pulse, found=0, result=0; next start clears err.
